prime_candidate_gen: RTL

Generates random odd 32-bit prime candidates for key generation and pushes them into the downstream 16-deep candidate FIFO. It uses a 32-bit LFSR and a bit-serial small-prime sieve (3, 5, 7, 11, 13), so only sieve survivors reach the FIFO and the primality tester behind it. It drives the FIFO's `write`/`data_in` directly and obeys its `fifo_full` back-pressure.

---
 rtl/prime_candidate_gen_if.sv | 10 +
 rtl/prime_candidate_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/prime_candidate_gen_if.sv
// Candidate FIFO write port: the generator drives the strobe and data,
// the FIFO answers with its full flag.
interface prime_candidate_gen_if;
    logic        write;
    logic [31:0] data_out;
    logic        fifo_full;

    modport master (output write, output data_out, input fifo_full);
    modport slave  (input write, input data_out, output fifo_full);
endinterface

// File: rtl/prime_candidate_gen.sv
// Random odd 32-bit prime candidate generator.
// A 32-bit Fibonacci LFSR proposes a value with MSB and LSB forced high.
// A bit-serial sieve then tests it against 3, 5, 7, 11 and 13, taking one
// bit per cycle.  Survivors are written into the downstream candidate FIFO
// under fifo_full back-pressure.

// One sieve lane: folds one more candidate bit (MSB first) into a residue mod P.
module prime_sieve_lane #(
    parameter logic [3:0] P = 4'd3
) (
    input  logic [3:0] r,
    input  logic       din,
    output logic [3:0] r_next,
    output logic       is_zero
);
    localparam logic [4:0] P5 = {1'b0, P};

    logic [4:0] t0;
    logic [4:0] t1;
    logic [3:0] t2;

    // 2r+bit < 2P for a reduced r, so one subtraction normally suffices;
    // the second keeps the lane self-correcting if r ever starts out of range.
    always_comb begin
        t0      = {r, din};
        t1      = (t0 >= P5) ? (t0 - P5) : t0;
        t2      = (t1 >= P5) ? 4'(t1 - P5) : t1[3:0];
        r_next  = t2;
        is_zero = (t2 == 4'd0);
    end
endmodule

module prime_candidate_gen #(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        seed_load,
    input  logic [31:0]                 seed,
    prime_candidate_gen_if.master       fifo,
    output logic                        busy,
    output logic [CNT_W-1:0]            accept_count,
    output logic [CNT_W-1:0]            reject_count
);
    localparam int NUM_P = 5;
    localparam logic [NUM_P-1:0][3:0] PRIMES = {4'd13, 4'd11, 4'd7, 4'd5, 4'd3};

    typedef enum logic [1:0] {IDLE, STEP, SIEVE, PUSH} state_t;

    state_t                   state_q, state_d;
    logic [31:0]              lfsr_q;
    logic [31:0]              lfsr_next;
    logic [31:0]              cand_q;
    logic [NUM_P-1:0][3:0]    res_q;
    logic [NUM_P-1:0][3:0]    res_next;
    logic [NUM_P-1:0]         lane_zero;
    logic [4:0]               idx_q;
    logic [CNT_W-1:0]         acc_q;
    logic [CNT_W-1:0]         rej_q;
    logic                     cand_bit;
    logic                     sieve_last;
    logic                     do_reject;
    logic                     do_accept;

    assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    assign cand_bit  = cand_q[idx_q];

    genvar g;
    for (g = 0; g < NUM_P; g++) begin : g_lane
        prime_sieve_lane #(.P(PRIMES[g])) u_lane (
            .r       (res_q[g]),
            .din     (cand_bit),
            .r_next  (res_next[g]),
            .is_zero (lane_zero[g])
        );
    end

    // Final sieve bit: decide on the residues being written this cycle.
    assign sieve_last = (state_q == SIEVE) && (idx_q == 5'd0);
    assign do_reject  = sieve_last && (|lane_zero);
    // Reset and seed reload both pre-empt a push, so the strobe is masked
    // in those cycles to keep the FIFO and accept_count in step.
    assign do_accept  = (state_q == PUSH) && !fifo.fifo_full && reset_n && !seed_load;

    assign fifo.write    = do_accept;
    assign fifo.data_out = cand_q;
    assign busy          = (state_q != IDLE);
    assign accept_count  = acc_q;
    assign reject_count  = rej_q;

    // Next-state logic; enable is only consulted when a candidate finishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (enable) state_d = STEP;
            STEP:  state_d = SIEVE;
            SIEVE: begin
                if (sieve_last) begin
                    if (|lane_zero) state_d = enable ? STEP : IDLE;
                    else            state_d = PUSH;
                end
            end
            PUSH:  if (!fifo.fifo_full) state_d = enable ? STEP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; a seed reload drops whatever candidate is in flight.
    always_ff @(posedge clk) begin
        if (!reset_n)       state_q <= IDLE;
        else if (seed_load) state_q <= IDLE;
        else                state_q <= state_d;
    end

    // LFSR: reloaded by seed_load (zero is not a legal LFSR state), stepped in STEP.
    always_ff @(posedge clk) begin
        if (!reset_n)                lfsr_q <= 32'h0000_0001;
        else if (seed_load)          lfsr_q <= (seed == 32'd0) ? 32'h0000_0001 : seed;
        else if (state_q == STEP)    lfsr_q <= lfsr_next;
    end

    // Candidate and sieve datapath: load on STEP, shift residues during SIEVE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cand_q <= 32'd0;
            res_q  <= '0;
            idx_q  <= 5'd0;
        end else if (!seed_load) begin
            if (state_q == STEP) begin
                cand_q <= lfsr_next | 32'h8000_0001;
                res_q  <= '0;
                idx_q  <= 5'd31;
            end else if (state_q == SIEVE) begin
                res_q <= res_next;
                if (idx_q != 5'd0) idx_q <= idx_q - 5'd1;
            end
        end
    end

    // Statistics counters, free-running modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
            rej_q <= '0;
        end else if (!seed_load) begin
            if (do_accept) acc_q <= acc_q + CNT_W'(1);
            if (do_reject) rej_q <= rej_q + CNT_W'(1);
        end
    end
endmodule
